// File: rtl/ft245_rx_ctrl.sv
// FT245 synchronous-FIFO receive controller: bursts bytes from the chip into a
// downstream FIFO, pausing whenever the FIFO has too little free space.
module ft245_rx_ctrl #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_WORDS = 2**ADDR_W,
  parameter int unsigned HEADROOM   = 4
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              enable,
  input  logic              ft_rxf_n,
  input  logic [DATA_W-1:0] ft_data_in,
  output logic              ft_oe_n,
  output logic              ft_rd_n,
  input  logic [ADDR_W:0]   fifo_wload,
  input  logic              fifo_wfull,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              fifo_wen,
  output logic [15:0]       rx_count,
  output logic              ovf_err
);

  localparam int unsigned LoadW = ADDR_W + 1;
  localparam logic [ADDR_W:0] Words    = LoadW'(FIFO_WORDS);
  localparam logic [ADDR_W:0] Headroom = LoadW'(HEADROOM);

  typedef enum logic [1:0] {StIdle, StTurn, StRead, StRelease} state_e;

  state_e              state_q, state_d;
  logic                oe_n_q, oe_n_d;
  logic                rd_n_q, rd_n_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W:0]     free_words;
  logic                room;

  assign free_words = Words - fifo_wload;
  assign room       = free_words > Headroom;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (enable && !ft_rxf_n && room) state_d = StTurn;
      StTurn:    state_d = StRead;
      StRead:    if (ft_rxf_n || !room || !enable) state_d = StRelease;
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so they leave the flops aligned with it.
  always_comb begin
    oe_n_d  = !((state_d == StTurn) || (state_d == StRead));
    rd_n_d  = (state_d != StRead);
    wen_d   = (state_q == StRead) && !ft_rxf_n;
    wdata_d = wen_d ? ft_data_in : wdata_q;
    cnt_d   = cnt_q + 16'(wen_q && !fifo_wfull);
    ovf_d   = ovf_q || (wen_q && fifo_wfull);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= StIdle;
      oe_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      oe_n_q  <= oe_n_d;
      rd_n_q  <= rd_n_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ft_oe_n    = oe_n_q;
  assign ft_rd_n    = rd_n_q;
  assign fifo_wen   = wen_q;
  assign fifo_wdata = wdata_q;
  assign rx_count   = cnt_q;
  assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_ft245_rx_ctrl.sv
// Bench for ft245_rx_ctrl: queue-based chip and FIFO models, a bus-protocol
// checker driven by the observed strobes, and a byte-order scoreboard.
module tb_ft245_rx_ctrl;

  localparam int AW    = 4;
  localparam int Words = 16;
  localparam int Hr    = 4;

  logic          wclk = 1'b0;
  logic          wrst = 1'b1;
  logic          enable = 1'b0;
  logic          ft_rxf_n = 1'b1;
  logic [7:0]    ft_data_in = 8'h00;
  logic          ft_oe_n, ft_rd_n;
  logic [AW:0]   fifo_wload = '0;
  logic          fifo_wfull = 1'b0;
  logic [7:0]    fifo_wdata;
  logic          fifo_wen;
  logic [15:0]   rx_count;
  logic          ovf_err;

  always #5 wclk = ~wclk;

  ft245_rx_ctrl #(
    .ADDR_W    (AW),
    .DATA_W    (8),
    .FIFO_WORDS(Words),
    .HEADROOM  (Hr)
  ) u_dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .enable    (enable),
    .ft_rxf_n  (ft_rxf_n),
    .ft_data_in(ft_data_in),
    .ft_oe_n   (ft_oe_n),
    .ft_rd_n   (ft_rd_n),
    .fifo_wload(fifo_wload),
    .fifo_wfull(fifo_wfull),
    .fifo_wdata(fifo_wdata),
    .fifo_wen  (fifo_wen),
    .rx_count  (rx_count),
    .ovf_err   (ovf_err)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] chip_q[$];
  logic [7:0] exp_q[$];
  int         level = 0;
  bit         drain = 1'b0;
  bit         hold = 1'b0;
  bit         force_full = 1'b0;
  int         exp_cnt = 0;
  bit         exp_ovf = 1'b0;
  bit         in_release = 1'b0;
  int         n_writes = 0;
  int         n_bursts = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit room_f(input int lvl);
    return (Words - lvl) > Hr;
  endfunction

  task automatic drive_inputs();
    ft_rxf_n   = (chip_q.size() == 0) || hold;
    ft_data_in = (chip_q.size() != 0) ? chip_q[0] : 8'h00;
    fifo_wload = level[AW:0];
    fifo_wfull = (level >= Words) || force_full;
  endtask

  // One clock: snapshot pre-edge values, cross the edge, then update models and check.
  task automatic step();
    logic       s_rst, s_en, s_rxf, s_oe, s_rd, s_wen, s_full, s_room, s_drain;
    logic [7:0] s_wdata, popped;
    int         s_level;
    bit         exp_oe, exp_rd, leave;
    s_rst = wrst;  s_en = enable;  s_rxf = ft_rxf_n;  s_oe = ft_oe_n;  s_rd = ft_rd_n;
    s_wen = fifo_wen;  s_full = fifo_wfull;  s_wdata = fifo_wdata;  s_drain = drain;
    s_level = level;  s_room = room_f(level);
    @(posedge wclk);
    #1;
    if (s_wen === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) check_eq("write_unexpected", 32'(s_wdata), 32'hffff_ffff);
      else check_eq("wdata_order", 32'(s_wdata), 32'(exp_q.pop_front()));
      if (s_full) exp_ovf = 1'b1;
      else begin
        exp_cnt = (exp_cnt + 1) & 16'hffff;
        level++;
      end
    end
    if (s_drain && s_level > 0) level--;
    if (s_rd === 1'b0 && !s_rxf) begin
      popped = chip_q.pop_front();
      if (!s_rst) exp_q.push_back(popped);
    end
    if (s_rst) begin
      exp_cnt = 0;
      exp_ovf = 1'b0;
      check_eq("rst_oe", 32'(ft_oe_n), 1);
      check_eq("rst_rd", 32'(ft_rd_n), 1);
      check_eq("rst_wen", 32'(fifo_wen), 0);
      check_eq("rst_wdata", 32'(fifo_wdata), 0);
    end else begin
      check_eq("wen", 32'(fifo_wen), 32'(!s_rd && !s_rxf));
      if (!(!s_rd && !s_rxf)) check_eq("wdata_hold", 32'(fifo_wdata), 32'(s_wdata));
      if (!s_rd) begin
        leave  = s_rxf || !s_room || !s_en;
        exp_oe = leave;
        exp_rd = leave;
      end else if (!s_oe) begin
        exp_oe = 1'b0;
        exp_rd = 1'b0;
      end else if (in_release) begin
        exp_oe = 1'b1;
        exp_rd = 1'b1;
      end else begin
        exp_oe = !(s_en && !s_rxf && s_room);
        exp_rd = 1'b1;
        if (!exp_oe) n_bursts++;
      end
      check_eq("oe_n", 32'(ft_oe_n), 32'(exp_oe));
      check_eq("rd_n", 32'(ft_rd_n), 32'(exp_rd));
    end
    check_eq("rx_count", 32'(rx_count), 32'(exp_cnt));
    check_eq("ovf_err", 32'(ovf_err), 32'(exp_ovf));
    in_release = !s_rst && (s_rd === 1'b0) && ft_rd_n;
    drive_inputs();
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    drive_inputs();
    step();
    step();
    wrst  = 1'b0;
    level = 0;
    drive_inputs();
  endtask

  task automatic run_drain(input int max_cycles);
    int k = 0;
    bit done;
    done = 1'b0;
    while (!done && k < max_cycles) begin
      step();
      k++;
      done = (chip_q.size() == 0) && (exp_q.size() == 0) && ft_rd_n && ft_oe_n;
    end
    check_eq("drain_done", 32'(done), 1);
    repeat (4) step();
  endtask

  task automatic wait_read(input int max_cycles);
    int k = 0;
    while (ft_rd_n && k < max_cycles) begin
      step();
      k++;
    end
    check_eq("read_started", 32'(ft_rd_n), 0);
  endtask

  initial begin
    int w0, b0, c0;
    drive_inputs();
    do_reset();
    check_eq("reset_count", 32'(rx_count), 0);
    check_eq("reset_ovf", 32'(ovf_err), 0);

    // Single byte
    w0 = n_writes;
    chip_q.push_back(8'hA5);
    enable = 1'b1;
    drain  = 1'b1;
    drive_inputs();
    run_drain(50);
    check_eq("single_writes", 32'(n_writes - w0), 1);
    check_eq("single_data", 32'(fifo_wdata), 32'h00A5);
    check_eq("single_count", 32'(rx_count), 1);

    // Long burst with the FIFO drained every cycle
    do_reset();
    w0 = n_writes;
    b0 = n_bursts;
    for (int i = 0; i < 300; i++) chip_q.push_back(8'(i % 44));
    drive_inputs();
    run_drain(400);
    check_eq("burst_writes", 32'(n_writes - w0), 300);
    check_eq("burst_single", 32'(n_bursts - b0), 1);
    check_eq("burst_count", 32'(rx_count), 300);

    // Backpressure: no FIFO reads, burst must stall on headroom
    w0 = n_writes;
    b0 = n_bursts;
    drain = 1'b0;
    for (int i = 0; i < 40; i++) chip_q.push_back(8'($urandom));
    drive_inputs();
    repeat (80) step();
    check_eq("bp_one_burst", 32'(n_bursts - b0), 1);
    check_eq("bp_no_room", 32'(room_f(level)), 0);
    check_eq("bp_pending", 32'(chip_q.size() > 0), 1);
    check_eq("bp_rd_idle", 32'(ft_rd_n), 1);
    check_eq("bp_ovf", 32'(ovf_err), 0);
    drain = 1'b1;
    drive_inputs();
    run_drain(500);
    check_eq("bp_writes", 32'(n_writes - w0), 40);

    // Forced full: byte dropped, error sticky
    c0 = exp_cnt;
    force_full = 1'b1;
    for (int i = 0; i < 3; i++) chip_q.push_back(8'(8'h60 + i));
    drive_inputs();
    run_drain(50);
    force_full = 1'b0;
    check_eq("drop_ovf", 32'(ovf_err), 1);
    check_eq("drop_count", 32'(rx_count), 32'(c0));
    chip_q.push_back(8'h11);
    chip_q.push_back(8'h22);
    drive_inputs();
    run_drain(50);
    check_eq("drop_sticky", 32'(ovf_err), 1);
    check_eq("drop_count2", 32'(rx_count), 32'((c0 + 2) & 16'hffff));

    // Enable dropped on the 5th READ cycle
    for (int i = 0; i < 20; i++) chip_q.push_back(8'($urandom));
    drive_inputs();
    wait_read(20);
    w0 = n_writes;
    repeat (4) step();
    enable = 1'b0;
    drive_inputs();
    repeat (8) step();
    check_eq("en_writes", 32'(n_writes - w0), 5);

    // Reset on the 3rd READ cycle
    enable = 1'b1;
    drive_inputs();
    wait_read(20);
    repeat (2) step();
    wrst = 1'b1;
    drive_inputs();
    step();
    wrst   = 1'b0;
    enable = 1'b0;
    chip_q.delete();
    drive_inputs();
    check_eq("mid_rst_rd", 32'(ft_rd_n), 1);
    check_eq("mid_rst_oe", 32'(ft_oe_n), 1);
    check_eq("mid_rst_wen", 32'(fifo_wen), 0);
    check_eq("mid_rst_count", 32'(rx_count), 0);
    w0 = n_writes;
    repeat (4) step();
    check_eq("mid_rst_nowrite", 32'(n_writes - w0), 0);
    check_eq("mid_rst_flushed", 32'(exp_q.size()), 0);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 8)) chip_q.push_back(8'($urandom));
      enable = ($urandom_range(0, 9) != 0);
      hold   = ($urandom_range(0, 7) == 0);
      drain  = ($urandom_range(0, 1) == 1);
      drive_inputs();
      step();
    end
    enable = 1'b1;
    hold   = 1'b0;
    drain  = 1'b1;
    drive_inputs();
    run_drain(2000);
    check_eq("rand_ovf", 32'(ovf_err), 0);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 65537; i++) chip_q.push_back(8'(i));
    drive_inputs();
    run_drain(70000);
    check_eq("wrap_count", 32'(rx_count), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
